// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin multi-master AHB arbiter with address/control/write-data mux
//   clk, rst         : clock, synchronous active-high reset
//   hbusreq, hlock   : per-master bus request and locked-transfer request
//   haddr_m..hwdata_m: per-master address-phase signals and write data
//   hready           : shared transfer-complete from the slave mux
//   hgrant, hmaster  : registered one-hot grant and address-phase owner index
//   hmaster_d        : registered data-phase owner index
//   hmastlock        : lock of the current owner
//   haddr..hsize     : owner's address phase, hwdata: data-phase owner's write data
module ahb_arbiter #(
    parameter int NMASTERS   = 2,
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int DEF_MASTER = 0,
    parameter int MAX_HOLD   = 16,
    localparam int MW        = (NMASTERS > 1) ? $clog2(NMASTERS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NMASTERS-1:0]               hbusreq,
    input  logic [NMASTERS-1:0]               hlock,
    input  logic [NMASTERS-1:0][AWIDTH-1:0]   haddr_m,
    input  logic [NMASTERS-1:0][1:0]          htrans_m,
    input  logic [NMASTERS-1:0]               hwrite_m,
    input  logic [NMASTERS-1:0][2:0]          hsize_m,
    input  logic [NMASTERS-1:0][DWIDTH-1:0]   hwdata_m,
    input  logic                              hready,
    output logic [NMASTERS-1:0]               hgrant,
    output logic [MW-1:0]                     hmaster,
    output logic [MW-1:0]                     hmaster_d,
    output logic                              hmastlock,
    output logic [AWIDTH-1:0]                 haddr,
    output logic [1:0]                        htrans,
    output logic                              hwrite,
    output logic [2:0]                        hsize,
    output logic [DWIDTH-1:0]                 hwdata
);
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold_cnt;
    logic [MW-1:0] winner;
    logic          found;
    logic          beat;
    logic          hold_full;
    logic          other_req;
    logic          rearb;

    always_comb begin
        haddr     = haddr_m[hmaster];
        htrans    = rst ? 2'b00 : htrans_m[hmaster];
        hwrite    = hwrite_m[hmaster];
        hsize     = hsize_m[hmaster];
        hwdata    = hwdata_m[hmaster_d];
        hmastlock = hlock[hmaster];
    end

    // NONSEQ and SEQ both have htrans[1] set.
    // The beat accepted this cycle is included so the forced cut lands
    // exactly on the MAX_HOLD-th accepted beat.
    always_comb begin
        beat      = htrans[1];
        hold_full = (int'(hold_cnt) + int'(beat)) >= MAX_HOLD;
        other_req = |(hbusreq & ~hgrant);
        rearb     = hready && !hmastlock &&
                    (htrans == 2'b00 || !hbusreq[hmaster] || (hold_full && other_req));
    end

    // Round-robin scan starting just after the owner and ending on the owner.
    always_comb begin
        winner = MW'(DEF_MASTER);
        found  = 1'b0;
        for (int i = 1; i <= NMASTERS; i++) begin
            if (!found && hbusreq[MW'((int'(hmaster) + i) % NMASTERS)]) begin
                winner = MW'((int'(hmaster) + i) % NMASTERS);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hmaster   <= MW'(DEF_MASTER);
            hmaster_d <= MW'(DEF_MASTER);
            hgrant    <= NMASTERS'(1) << DEF_MASTER;
            hold_cnt  <= '0;
        end else if (hready) begin
            hmaster_d <= hmaster;
            if (rearb && winner != hmaster) begin
                hmaster  <= winner;
                hgrant   <= NMASTERS'(1) << winner;
                hold_cnt <= '0;
            end else if (beat && int'(hold_cnt) < MAX_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
endmodule
